// File: rtl/fp32_acc.sv
// FP32 dot-product accumulator behind the PE multiplier: framed sums with flush-to-zero and truncation.
// Optional term counter and acc_count port enabled by defining FP32_ACC_STATS_EN.
module fp32_acc #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [31:0]      prod_in,
  input  logic             first_in,
  input  logic             last_in,
  output logic             out_valid,
  output logic [31:0]      out_data,
  input  logic             out_ready,
  output logic             overrun
`ifdef FP32_ACC_STATS_EN
  ,
  output logic [CNT_W-1:0] acc_count
`endif
);

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  // Handshake: out_data transfers on any clock edge where out_valid && out_ready;
  // out_valid/out_data hold until then, and the input stream is never stalled.

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [7:0]         ea, eb, e_big, e_small, ediff;
    logic [23:0]        ma, mb;
    logic               a_inf, b_inf, a_big, s_big, s_small;
    logic [26:0]        m_big, m_small;
    logic [27:0]        sum;
    logic [4:0]         lz;
    logic [26:0]        norm;
    logic signed [9:0]  e_res;
    logic [22:0]        frac;
    logic [31:0]        r;
    ea    = a[30:23];
    eb    = b[30:23];
    ma    = (ea == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
    mb    = (eb == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
    a_inf = (ea == 8'hFF);
    b_inf = (eb == 8'hFF);
    r     = 32'd0;
    frac  = 23'd0;
    e_res = 10'sd0;
    lz    = 5'd0;
    norm  = 27'd0;
    if (a_inf && b_inf && (a[31] != b[31])) begin
      r = 32'h7FC00000;
    end else if (a_inf) begin
      r = {a[31], 8'hFF, 23'd0};
    end else if (b_inf) begin
      r = {b[31], 8'hFF, 23'd0};
    end else begin
      // Larger magnitude operand sets the exponent and the result sign.
      a_big   = ({ea, ma} >= {eb, mb});
      e_big   = a_big ? ea : eb;
      e_small = a_big ? eb : ea;
      m_big   = a_big ? {ma, 3'b000} : {mb, 3'b000};
      m_small = a_big ? {mb, 3'b000} : {ma, 3'b000};
      s_big   = a_big ? a[31] : b[31];
      s_small = a_big ? b[31] : a[31];
      ediff   = e_big - e_small;
      m_small = (ediff >= 8'd27) ? 27'd0 : (m_small >> ediff);
      if (s_big == s_small) sum = {1'b0, m_big} + {1'b0, m_small};
      else                  sum = {1'b0, m_big} - {1'b0, m_small};
      if (sum == 28'd0) begin
        r = 32'd0;
      end else begin
        if (sum[27]) begin
          e_res = $signed({2'b00, e_big}) + 10'sd1;
          frac  = sum[26:4];
        end else begin
          for (int i = 0; i < 27; i++) begin
            if (sum[i]) lz = 5'(26 - i);
          end
          norm  = sum[26:0] << lz;
          e_res = $signed({2'b00, e_big}) - $signed({5'd0, lz});
          frac  = norm[25:3];
        end
        if (e_res >= 10'sd255)   r = {s_big, 8'hFF, 23'd0};
        else if (e_res <= 10'sd0) r = {s_big, 31'd0};
        else                      r = {s_big, e_res[7:0], frac};
      end
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        overrun_q, overrun_d;
  logic        restart;
  logic        complete;
  logic [31:0] sum_now;

  assign restart  = (state_q == IDLE) || first_in;
  assign complete = valid_in && last_in;
  assign sum_now  = fadd(restart ? 32'd0 : acc_q, prod_in);

`ifdef FP32_ACC_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_now, acc_count_q, acc_count_d;
  assign cnt_now = restart ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + CNT_W'(1));
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    overrun_d   = overrun_q;
`ifdef FP32_ACC_STATS_EN
    cnt_d       = cnt_q;
    acc_count_d = acc_count_q;
`endif
    if (valid_in) begin
      if (last_in) begin
        state_d = IDLE;
        acc_d   = 32'd0;
      end else begin
        state_d = ACCUM;
        acc_d   = sum_now;
      end
`ifdef FP32_ACC_STATS_EN
      cnt_d = last_in ? CNT_W'(0) : cnt_now;
`endif
    end
    // A completion is dropped only when the held result is not leaving this cycle.
    if (complete) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        out_data_d  = sum_now;
`ifdef FP32_ACC_STATS_EN
        acc_count_d = cnt_now;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= 32'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      overrun_q   <= 1'b0;
`ifdef FP32_ACC_STATS_EN
      cnt_q       <= '0;
      acc_count_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overrun_q   <= overrun_d;
`ifdef FP32_ACC_STATS_EN
      cnt_q       <= cnt_d;
      acc_count_q <= acc_count_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign overrun   = overrun_q;
`ifdef FP32_ACC_STATS_EN
  assign acc_count = acc_count_q;
`endif

endmodule

// File: tb/tb_fp32_acc.sv
// Directed bench for fp32_acc: framed sums, FP corner cases, output handshake, overrun and reset.
// Builds with or without FP32_ACC_STATS_EN.
module tb_fp32_acc;

  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             valid_in;
  logic [31:0]      prod_in;
  logic             first_in;
  logic             last_in;
  logic             out_valid;
  logic [31:0]      out_data;
  logic             out_ready;
  logic             overrun;
`ifdef FP32_ACC_STATS_EN
  logic [CNT_W-1:0] acc_count;
`endif

  int checks;
  int failures;

  fp32_acc #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .prod_in   (prod_in),
    .first_in  (first_in),
    .last_in   (last_in),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .overrun   (overrun)
`ifdef FP32_ACC_STATS_EN
    ,
    .acc_count (acc_count)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drivers: inputs change on negedge, DUT samples on posedge, outputs checked on the following negedge.
  task automatic send(input logic f, input logic l, input logic [31:0] d);
    @(negedge clk);
    valid_in = 1'b1;
    first_in = f;
    last_in  = l;
    prod_in  = d;
    @(negedge clk);
    valid_in = 1'b0;
    first_in = 1'b0;
    last_in  = 1'b0;
    prod_in  = 32'd0;
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset(2);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=00000000", out_data); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
`ifdef FP32_ACC_STATS_EN
    checks++; if (acc_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", acc_count); end
`endif
  endtask

  task automatic test_three_term();
    out_ready = 1'b1;
    send(1'b1, 1'b0, 32'h3F800000);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL three_mid_valid got=%b exp=0", out_valid); end
    send(1'b0, 1'b0, 32'h40000000);
    send(1'b0, 1'b1, 32'h40400000);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL three_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 32'h40C00000) begin failures++; $display("FAIL three_data got=%h exp=40c00000", out_data); end
`ifdef FP32_ACC_STATS_EN
    checks++; if (acc_count !== 16'd3) begin failures++; $display("FAIL three_count got=%0d exp=3", acc_count); end
`endif
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    send(1'b1, 1'b1, 32'h3F800000);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 32'h3F800000) begin failures++; $display("FAIL single_data got=%h exp=3f800000", out_data); end
`ifdef FP32_ACC_STATS_EN
    checks++; if (acc_count !== 16'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", acc_count); end
`endif
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_one_cycle got=%b exp=0", out_valid); end
  endtask

  task automatic test_arith();
    out_ready = 1'b1;
    // Cancellation, then a subnormal that must flush.
    send(1'b1, 1'b0, 32'h3FC00000);
    send(1'b0, 1'b0, 32'hBFC00000);
    send(1'b0, 1'b1, 32'h00000001);
    checks++; if (out_data !== 32'h00000000) begin failures++; $display("FAIL cancel_data got=%h exp=00000000", out_data); end
    // Overflow to infinity.
    send(1'b1, 1'b0, 32'h7F000000);
    send(1'b0, 1'b1, 32'h7F000000);
    checks++; if (out_data !== 32'h7F800000) begin failures++; $display("FAIL overflow_data got=%h exp=7f800000", out_data); end
    // Opposite infinities.
    send(1'b1, 1'b0, 32'h7F800000);
    send(1'b0, 1'b1, 32'hFF800000);
    checks++; if (out_data !== 32'h7FC00000) begin failures++; $display("FAIL inf_nan_data got=%h exp=7fc00000", out_data); end
    // 2.0 - 1.5 = 0.5: left normalization by two.
    send(1'b1, 1'b0, 32'h40000000);
    send(1'b0, 1'b1, 32'hBFC00000);
    checks++; if (out_data !== 32'h3F000000) begin failures++; $display("FAIL norm_data got=%h exp=3f000000", out_data); end
    // 1.0 - 3.0 = -2.0: sign from the larger magnitude.
    send(1'b1, 1'b0, 32'h3F800000);
    send(1'b0, 1'b1, 32'hC0400000);
    checks++; if (out_data !== 32'hC0000000) begin failures++; $display("FAIL sign_data got=%h exp=c0000000", out_data); end
    // 1.0 + 1.5*2^-24: guard bits 110 are truncated, not rounded.
    send(1'b1, 1'b0, 32'h3F800000);
    send(1'b0, 1'b1, 32'h33C00000);
    checks++; if (out_data !== 32'h3F800000) begin failures++; $display("FAIL trunc_data got=%h exp=3f800000", out_data); end
    // first_in mid-sum restarts accumulation.
    send(1'b1, 1'b0, 32'h40400000);
    send(1'b1, 1'b1, 32'h40000000);
    checks++; if (out_data !== 32'h40000000) begin failures++; $display("FAIL restart_data got=%h exp=40000000", out_data); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    @(negedge clk);
    valid_in = 1'b1; first_in = 1'b1; last_in = 1'b1; prod_in = 32'h3F800000;
    @(negedge clk);
    prod_in = 32'h40400000;
    @(negedge clk);
    valid_in = 1'b0; first_in = 1'b0; last_in = 1'b0; prod_in = 32'd0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 32'h40400000) begin failures++; $display("FAIL b2b_data got=%h exp=40400000", out_data); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
    @(negedge clk);
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    send(1'b1, 1'b0, 32'h3F800000);
    send(1'b0, 1'b0, 32'h40000000);
    send(1'b0, 1'b1, 32'h40400000);
    checks++; if (out_data !== 32'h40C00000) begin failures++; $display("FAIL bp_first_data got=%h exp=40c00000", out_data); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL bp_no_overrun got=%b exp=0", overrun); end
    send(1'b1, 1'b1, 32'h3F800000);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 32'h40C00000) begin failures++; $display("FAIL bp_hold_data got=%h exp=40c00000", out_data); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL bp_overrun got=%b exp=1", overrun); end
`ifdef FP32_ACC_STATS_EN
    checks++; if (acc_count !== 16'd3) begin failures++; $display("FAIL bp_count got=%0d exp=3", acc_count); end
`endif
    repeat (2) @(negedge clk);
    checks++; if (out_data !== 32'h40C00000) begin failures++; $display("FAIL bp_stable_data got=%h exp=40c00000", out_data); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL bp_sticky got=%b exp=1", overrun); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send(1'b1, 1'b0, 32'h3F800000);
    send(1'b0, 1'b0, 32'h40000000);
    apply_reset(1);
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rst_mid_overrun got=%b exp=0", overrun); end
    send(1'b1, 1'b1, 32'h40000000);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rst_mid_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 32'h40000000) begin failures++; $display("FAIL rst_mid_data got=%h exp=40000000", out_data); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rst_mid_overrun2 got=%b exp=0", overrun); end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b1;
    valid_in  = 1'b0;
    prod_in   = 32'd0;
    first_in  = 1'b0;
    last_in   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_three_term();
    test_single();
    test_arith();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
